// File: rtl/display_scanner_pkg.sv
// Shared types and active-low seven-segment codes (bit 6 = a ... bit 0 = g)
// for the multiplexed display scanner.
package display_scanner_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;
    localparam seg_t SEG_ZERO  = 7'h01;
    localparam seg_t SEG_ONE   = 7'h4F;
    localparam seg_t SEG_TWO   = 7'h12;
    localparam seg_t SEG_THREE = 7'h06;
    localparam seg_t SEG_FOUR  = 7'h4C;
    localparam seg_t SEG_FIVE  = 7'h24;
    localparam seg_t SEG_SIX   = 7'h20;
    localparam seg_t SEG_SEVEN = 7'h0F;
    localparam seg_t SEG_EIGHT = 7'h00;
    localparam seg_t SEG_NINE  = 7'h0C;

endpackage

// File: rtl/display_scanner_if.sv
// Load/enable side and display pins of the scanner, bundled with
// master (controller) and slave (scanner) views.
interface display_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value_in;
    logic                    load;
    logic                    enable;
    logic                    pending;
    logic                    frame_tick;
    logic [NUM_DIGITS-1:0]   anode_n;
    logic [6:0]              segments_n;

    modport master (
        output value_in, load, enable,
        input  pending, frame_tick, anode_n, segments_n
    );

    modport slave (
        input  value_in, load, enable,
        output pending, frame_tick, anode_n, segments_n
    );
endinterface

// File: rtl/seven_segment_digit.sv
// Shared BCD to active-low seven-segment decoder; codes 10..15 and a
// forced blank both produce SEG_BLANK.
module seven_segment_digit
    import display_scanner_pkg::*;
(
    input  bcd_t digit,
    input  logic blank,
    output seg_t segments_n
);

    // NOTE: default assignment first keeps this combinational block latch-free.
    always_comb begin
        segments_n = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    segments_n = SEG_ZERO;
                4'd1:    segments_n = SEG_ONE;
                4'd2:    segments_n = SEG_TWO;
                4'd3:    segments_n = SEG_THREE;
                4'd4:    segments_n = SEG_FOUR;
                4'd5:    segments_n = SEG_FIVE;
                4'd6:    segments_n = SEG_SIX;
                4'd7:    segments_n = SEG_SEVEN;
                4'd8:    segments_n = SEG_EIGHT;
                4'd9:    segments_n = SEG_NINE;
                default: segments_n = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/display_scanner.sv
// Multiplexed seven-segment scanner with frame-synchronous value commit.
// Define SCAN_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module display_scanner
    import display_scanner_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input logic              clk,
    input logic              reset,
    display_scanner_if.slave bus
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] staging;
    logic [4*NUM_DIGITS-1:0] display;
    logic                    pending_q;
    logic                    frame_tick_q;
    logic [NUM_DIGITS-1:0]   anode_q;
    seg_t                    seg_q;

    logic slot_end;
    logic boundary;
    logic commit;

    always_comb begin
        slot_end = (cnt == CNT_LAST);
        boundary = bus.enable && slot_end && (idx == IDX_LAST);
        // With scanning stopped there is no frame to tear, so commit at once.
        commit   = pending_q && (boundary || !bus.enable);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            idx          <= '0;
            frame_tick_q <= 1'b0;
        end else if (!bus.enable) begin
            cnt          <= '0;
            idx          <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            frame_tick_q <= boundary;
            if (slot_end) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // NOTE: staging and display are plain registers, so they take the reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            staging   <= '0;
            display   <= '0;
            pending_q <= 1'b0;
        end else begin
            if (commit) display <= staging;
            if (bus.load) begin
                staging   <= bus.value_in;
                pending_q <= 1'b1;
            end else if (commit) begin
                pending_q <= 1'b0;
            end
        end
    end

    bcd_t                  digits [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] lead_blank;
    seg_t                  dec_seg;

    always_comb begin
        for (int k = 0; k < NUM_DIGITS; k++) digits[k] = display[4*k +: 4];
    end

`ifdef SCAN_LEADING_ZERO_BLANK_EN
    // Walk down from the top digit; blank while every digit so far is zero.
    always_comb begin
        logic leading;
        leading    = 1'b1;
        lead_blank = '0;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            leading       = leading && (digits[k] == 4'd0);
            lead_blank[k] = leading;
        end
    end
`else
    assign lead_blank = '0;
`endif

    seven_segment_digit u_decoder (
        .digit      (digits[idx]),
        .blank      (lead_blank[idx]),
        .segments_n (dec_seg)
    );

    // Anode and segments leave through one register stage; slot start is dead time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            anode_q <= '1;
            seg_q   <= SEG_BLANK;
        end else if (!bus.enable) begin
            anode_q <= '1;
            seg_q   <= SEG_BLANK;
        end else begin
            anode_q <= (cnt == '0) ? '1 : ~(NUM_DIGITS'(1) << idx);
            seg_q   <= dec_seg;
        end
    end

    assign bus.pending    = pending_q;
    assign bus.frame_tick = frame_tick_q;
    assign bus.anode_n    = anode_q;
    assign bus.segments_n = seg_q;

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner (NUM_DIGITS=4, REFRESH_DIV=4):
// directed scenarios plus random loads/enables against a time-based model.
module tb_display_scanner;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int FRAME = N * DIV;

    logic clk = 1'b0;
    logic reset;

    display_scanner_if #(.NUM_DIGITS(N)) bus ();

    display_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] seg_ref [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                 7'h00, 7'h0C, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

    // Reference model: cycles since scanning started, plus the value pipeline.
    int          m_time;
    logic        m_pend;
    logic [15:0] m_stage;
    logic [15:0] m_show;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] expected_seg(input logic [15:0] val, input int k);
        logic [15:0] upper;
        upper = val >> (4 * k);
`ifdef SCAN_LEADING_ZERO_BLANK_EN
        if (k > 0 && upper == 16'd0) return 7'h7F;
`endif
        return seg_ref[upper[3:0]];
    endfunction

    task automatic model_reset();
        m_time  = 0;
        m_pend  = 1'b0;
        m_stage = 16'h0000;
        m_show  = 16'h0000;
    endtask

    // Apply inputs, predict the edge from the model, clock once, compare.
    task automatic step(input logic ld, input logic [15:0] v, input logic en);
        logic [3:0] exp_anode;
        logic [6:0] exp_seg;
        logic       exp_tick;
        logic       commit;
        int         slot;
        bus.load     = ld;
        bus.value_in = v;
        bus.enable   = en;
        slot         = (m_time / DIV) % N;
        exp_tick     = en && (m_time % FRAME == FRAME - 1);
        if (!en) begin
            exp_anode = 4'hF;
            exp_seg   = 7'h7F;
        end else begin
            exp_anode = (m_time % DIV == 0) ? 4'hF : ~(4'b0001 << slot);
            exp_seg   = expected_seg(m_show, slot);
        end
        commit = m_pend && (exp_tick || !en);
        if (commit) m_show = m_stage;
        if (ld) begin
            m_stage = v;
            m_pend  = 1'b1;
        end else if (commit) begin
            m_pend = 1'b0;
        end
        m_time = en ? m_time + 1 : 0;
        @(posedge clk);
        #1;
        check("anode_n", 32'(bus.anode_n), 32'(exp_anode));
        if (exp_anode != 4'hF || !en) check("segments_n", 32'(bus.segments_n), 32'(exp_seg));
        check("frame_tick", 32'(bus.frame_tick), 32'(exp_tick));
        check("pending", 32'(bus.pending), 32'(m_pend));
    endtask

    task automatic idle(input int cycles, input logic en);
        for (int i = 0; i < cycles; i++) step(1'b0, 16'h0000, en);
    endtask

    task automatic run_to_pos(input int pos);
        for (int i = 0; i < FRAME && (m_time % FRAME) != pos; i++) step(1'b0, 16'h0000, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_anode"}, 32'(bus.anode_n), 32'hF);
        check({tag, "_seg"}, 32'(bus.segments_n), 32'h7F);
        check({tag, "_tick"}, 32'(bus.frame_tick), 32'h0);
        check({tag, "_pending"}, 32'(bus.pending), 32'h0);
    endtask

    // Assert reset between edges, check it acts at once, hold across an edge.
    task automatic pulse_reset();
        #1;
        reset    = 1'b1;
        bus.load = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(posedge clk);
        #1;
        check_reset_outputs("held_reset");
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        reset        = 1'b1;
        bus.load     = 1'b0;
        bus.enable   = 1'b0;
        bus.value_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        reset = 1'b0;

        // Basic scan of 1234, then a mid-frame load of 5678.
        step(1'b1, 16'h1234, 1'b1);
        idle(2 * FRAME + 3, 1'b1);
        run_to_pos(5);
        step(1'b1, 16'h5678, 1'b1);
        idle(FRAME + 4, 1'b1);

        // Two loads inside one frame: only the second is ever shown.
        run_to_pos(2);
        step(1'b1, 16'h1111, 1'b1);
        idle(3, 1'b1);
        step(1'b1, 16'h2222, 1'b1);
        idle(FRAME + 6, 1'b1);

        // Load while pending, then load exactly on the boundary edge.
        run_to_pos(8);
        step(1'b1, 16'h8765, 1'b1);
        run_to_pos(FRAME - 1);
        step(1'b1, 16'h4321, 1'b1);
        check("boundary_load_pending", 32'(bus.pending), 32'h1);
        idle(2 * FRAME, 1'b1);

        // Leading zeros and an out-of-range BCD code.
        step(1'b1, 16'h00A7, 1'b1);
        idle(2 * FRAME + 2, 1'b1);

        // Disable mid-scan with a load, then resume at index 0.
        run_to_pos(6);
        step(1'b1, 16'h9999, 1'b0);
        idle(4, 1'b0);
        idle(2 * FRAME, 1'b1);

        // Reset while a value is pending: it must be discarded.
        run_to_pos(3);
        step(1'b1, 16'h2468, 1'b1);
        pulse_reset();
        idle(2, 1'b1);
        step(1'b0, 16'h0000, 1'b1);
        check("zero_after_reset", 32'(bus.segments_n), 32'h01);
        idle(FRAME, 1'b1);

        // Random loads, enable changes and an occasional reset.
        begin
            logic en;
            en = 1'b1;
            for (int i = 0; i < 1500; i++) begin
                logic        ld;
                logic [15:0] v;
                if ($urandom_range(0, 39) == 0) en = ~en;
                ld = ($urandom_range(0, 9) == 0);
                v  = 16'($urandom);
                if ($urandom_range(0, 2) == 0) v = 16'(v & 16'h00FF);
                step(ld, v, en);
                if ($urandom_range(0, 499) == 0) pulse_reset();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed seven-segment digits, range 2..8.
REQ-002 Parameter REFRESH_DIV, default 50000: clk cycles per digit slot, minimum 4.
REQ-003 Port clk, input, 1: single system clock; all state on rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port value_in, input, 4*NUM_DIGITS: BCD digits; digit k is bits [4k+3:4k], and digit 0 is rightmost.
REQ-006 Port load, input, 1: one-cycle strobe that captures value_in.
REQ-007 Port enable, input, 1: scanning enable; low blanks the display.
REQ-008 Port pending, output, 1: high while a captured value awaits commit.
REQ-009 Port frame_tick, output, 1: one-cycle pulse at each frame boundary.
REQ-010 Port anode_n, output, NUM_DIGITS: active-low digit select.
REQ-011 Port segments_n, output, 7: active-low segments, bit order abc_defg (bit 6 = a).

Function
REQ-012 The refresh counter shall count 0..REFRESH_DIV-1 and then wrap; the digit index shall advance on the wrap and go from NUM_DIGITS-1 to 0.
REQ-013 A frame boundary is the edge at which the index wraps to 0; frame_tick shall be high for exactly the cycle after that edge.
REQ-014 On load, value_in shall be captured into a staging register and pending set on the same edge.
REQ-015 At a frame boundary with pending high, staging shall be copied to the display register and pending cleared, so digits never tear mid-frame.
REQ-016 Load while pending shall overwrite staging, and pending shall stay high.
REQ-017 Load on a boundary edge shall commit the old staging, capture the new value, and leave pending high.
REQ-018 anode_n and segments_n shall be registered together, with a one-cycle latency from index change.
REQ-019 Dead time: when the refresh counter is 0, anode_n shall be all ones to prevent ghosting.
REQ-020 BCD codes 10..15 shall drive segments_n all ones (blank).
REQ-021 While enable is low, the refresh counter and index shall be held at 0, anode_n and segments_n all ones, and frame_tick 0.
REQ-022 While enable is low, load shall still be accepted, and a pending value shall commit on the following edge.
REQ-023 On enable rising, scanning shall restart at index 0 with counter 0.

Reset
REQ-024 Reset shall asynchronously set the counter to 0, index 0, staging and display to 0, pending 0, frame_tick 0, anode_n all ones and segments_n all ones.
REQ-025 Reset asserted mid-frame shall discard any pending value, with no commit.

Configuration
REQ-026 With SCAN_LEADING_ZERO_BLANK_EN defined, digits above the most significant nonzero digit shall show blank, and digit 0 shall always show.
REQ-027 Without SCAN_LEADING_ZERO_BLANK_EN, all digits shall display as decoded, including leading zeros.

Structure
REQ-028 A shared package shall hold the active-low segment constants SEG_BLANK and SEG_ZERO..SEG_NINE, and the BCD digit typedef.
REQ-029 A single instance of seven_segment_digit shall serve as the shared decoder, fed by the currently selected display digit.

Verification (NUM_DIGITS=4, REFRESH_DIV=4)
REQ-030 Reset release, enable=1, load 0x1234 -> after one frame, anode_n cycles 1110, 1101, 1011, 0111 with segments 4, 3, 2, 1 (0x4C, 0x06, 0x12, 0x4F), and a dead cycle per slot.
REQ-031 Load 0x5678 mid-frame -> pending=1, display unchanged until the boundary, then frame_tick pulses, pending=0, and 0x5678 is shown.
REQ-032 Load 0x1111 then 0x2222 within one frame -> only 0x2222 is ever displayed.
REQ-033 Load 0x00A7 with the macro defined -> digit 0 shows 7, digits 1..3 are blank (7F); without the macro -> digit 1 is blank (code A), and digits 2..3 show 0 (0x01).
REQ-034 enable=0 mid-scan with a load of 0x9999 -> outputs all ones, pending clears next cycle; enable=1 -> scan resumes at index 0 showing 9 (0x0C).
REQ-035 Reset asserted during pending -> all outputs at reset values immediately; after release the display shows 0000.
